// File: rtl/popcount_window_accumulator.sv
// Sums clamped popcount samples over a window of up to WINDOW accepted transfers,
// then holds the window sum, sample count and threshold flag until the consumer takes it.
module popcount_window_accumulator #(
  parameter int WINDOW = 16,
  parameter int ACC_W  = 10,
  parameter int THRESH = 256,
  localparam int N_W   = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       in_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_sum,
  output logic [N_W-1:0]   out_n,
  output logic             out_above,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_range
);

  if (ACC_W < $clog2(32 * WINDOW + 1)) begin : g_acc_w_check
    $error("ACC_W too narrow for 32*WINDOW");
  end

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [N_W-1:0]   on_q, on_d;
  logic             above_q, above_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             accept;
  logic             close;
  logic [ACC_W-1:0] acc_nxt;
  logic [N_W-1:0]   n_nxt;

  // Saturate an out-of-range sample to the largest legal popcount.
  function automatic logic [ACC_W-1:0] clamp_count(input logic [5:0] x);
    return (x > 6'd32) ? ACC_W'(32) : ACC_W'(x);
  endfunction

  function automatic logic above_thresh(input logic [ACC_W-1:0] s);
    return 64'(s) >= 64'(THRESH);
  endfunction

  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid & in_ready;
  assign acc_nxt  = acc_q + (accept ? clamp_count(in_count) : '0);
  assign n_nxt    = n_q + N_W'(accept);
  // A flush closes the window only if it would contain at least one sample.
  assign close    = (state_q == ACCUM) &&
                    ((accept && (n_nxt == N_W'(WINDOW))) || (flush && ((n_q != '0) || accept)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    sum_d   = sum_q;
    on_d    = on_q;
    above_d = above_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ACCUM: begin
        acc_d = acc_nxt;
        n_d   = n_nxt;
        if (accept && (in_count > 6'd32)) err_d = 1'b1;
        if (close) begin
          state_d = HOLD;
          sum_d   = acc_nxt;
          on_d    = n_nxt;
          above_d = above_thresh(acc_nxt);
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          state_d = ACCUM;
          valid_d = 1'b0;
          acc_d   = '0;
          n_d     = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      on_q    <= '0;
      above_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      on_q    <= on_d;
      above_q <= above_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_n     = on_q;
  assign out_above = above_q;
  assign out_valid = valid_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Bench for popcount_window_accumulator: directed scenarios plus random traffic,
// all compared against a queue-based reference model every cycle.
module tb_popcount_window_accumulator;
  localparam int WINDOW = 16;
  localparam int ACC_W  = 10;
  localparam int THRESH = 256;
  localparam int N_W    = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       in_count;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [ACC_W-1:0] out_sum;
  logic [N_W-1:0]   out_n;
  logic             out_above;
  logic             out_valid;
  logic             out_ready;
  logic             err_range;

  popcount_window_accumulator #(.WINDOW(WINDOW), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_count(in_count), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_sum(out_sum), .out_n(out_n), .out_above(out_above),
    .out_valid(out_valid), .out_ready(out_ready), .err_range(err_range)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the open window is a list of clamped samples.
  int q[$];
  bit m_hold, m_valid, m_above, m_err;
  int m_sum, m_n;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit iv, input int ic, input bit fl, input bit ordy);
    int s;
    if (r) begin
      q.delete();
      m_hold = 0; m_valid = 0; m_above = 0; m_err = 0; m_sum = 0; m_n = 0;
    end else if (!m_hold) begin
      if (iv) begin
        q.push_back(ic > 32 ? 32 : ic);
        if (ic > 32) m_err = 1;
      end
      if ((iv && q.size() == WINDOW) || (fl && q.size() > 0)) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_hold = 1; m_valid = 1; m_sum = s; m_n = q.size(); m_above = (s >= THRESH);
      end
    end else if (ordy) begin
      m_hold = 0; m_valid = 0;
      q.delete();
    end
  endtask

  task automatic cyc(input bit r, input bit iv, input int ic, input bit fl, input bit ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_count = 6'(ic); flush = fl; out_ready = ordy;
    model_step(r, iv, ic, fl, ordy);
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, !m_hold);
    chk("out_valid", out_valid, m_valid);
    chk("out_sum", out_sum, m_sum);
    chk("out_n", out_n, m_n);
    chk("out_above", out_above, m_above);
    chk("err_range", err_range, m_err);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_count = 0; flush = 0; out_ready = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_sum", out_sum, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);

    // Full window of maximal samples
    for (int i = 0; i < 16; i++) cyc(0, 1, 32, 0, 1);
    chk("s1_valid", out_valid, 1);
    chk("s1_sum", out_sum, 512);
    chk("s1_n", out_n, 16);
    chk("s1_above", out_above, 1);
    cyc(0, 0, 0, 0, 1);
    chk("s1_valid_one_cycle", out_valid, 0);

    // Flush after three samples
    for (int i = 0; i < 3; i++) cyc(0, 1, 5, 0, 1);
    cyc(0, 0, 0, 1, 1);
    chk("s2_sum", out_sum, 15);
    chk("s2_n", out_n, 3);
    chk("s2_above", out_above, 0);
    cyc(0, 0, 0, 0, 1);

    // Flush coinciding with an accept
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 7, 1, 1);
    chk("s3_sum", out_sum, 9);
    chk("s3_n", out_n, 3);
    cyc(0, 0, 0, 0, 1);

    // Back-pressure while holding a result
    for (int i = 0; i < 16; i++) cyc(0, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 3, 1, 0);
      chk("s4_ready_low", in_ready, 0);
      chk("s4_sum_stable", out_sum, 32);
      chk("s4_n_stable", out_n, 16);
    end
    cyc(0, 0, 0, 0, 1);
    chk("s4_ready_back", in_ready, 1);
    chk("s4_valid_drop", out_valid, 0);

    // Out-of-range sample and a lone flush
    cyc(0, 1, 40, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    chk("s5_sum", out_sum, 32);
    chk("s5_err", err_range, 1);
    cyc(0, 0, 0, 0, 1);
    chk("s5_err_sticky", err_range, 1);
    cyc(0, 0, 0, 1, 1);
    chk("s5_lone_flush", out_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s5_lone_flush2", out_valid, 0);

    // Reset mid-window
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 1);
    cyc(1, 1, 9, 1, 1);
    chk("s6_err_cleared", err_range, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 0, 1);
    chk("s6_sum", out_sum, 16);
    chk("s6_n", out_n, 16);
    cyc(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 32)),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
